// File: rtl/temp_poly_converter.sv
// Cubic calibration polynomial evaluator (Horner form) on one sequential shift-add multiplier.
// Converts a raw unsigned Q0.16 sensor count into a signed Q8.8 temperature.
module temp_poly_converter #(
  parameter int RAW_W  = 16,
  parameter int COEF_W = 32,
  parameter int TEMP_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     raw_valid,
  input  logic [RAW_W-1:0]         raw_data,
  output logic                     raw_ready,
  input  logic signed [COEF_W-1:0] ofs,
  input  logic signed [COEF_W-1:0] gain1,
  input  logic signed [COEF_W-1:0] gain2,
  input  logic signed [COEF_W-1:0] gain3,
  output logic signed [TEMP_W-1:0] temp_out,
  output logic [RAW_W-1:0]         raw_out,
  output logic                     temp_valid,
  output logic                     busy,
  output logic                     sat_flag
);

  localparam int PROD_W  = COEF_W + RAW_W;
  localparam int T_SHIFT = 12;                  // Q12.20 -> Q8.8
  localparam int TW_W    = COEF_W - T_SHIFT;
  localparam int CNT_W   = $clog2(RAW_W);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MUL, S_ADD, S_DONE} state_t;

  // {overflow, clamped value} for the accumulator sum
  function automatic logic [COEF_W:0] sat_coef(input logic signed [COEF_W:0] v);
    logic [COEF_W:0] r;
    if (v[COEF_W] != v[COEF_W-1])
      r = v[COEF_W] ? {1'b1, 1'b1, {(COEF_W-1){1'b0}}} : {1'b1, 1'b0, {(COEF_W-1){1'b1}}};
    else
      r = {1'b0, v[COEF_W-1:0]};
    return r;
  endfunction

  // {overflow, clamped value} for the Q8.8 output
  function automatic logic [TEMP_W:0] sat_temp(input logic signed [TW_W-1:0] v);
    logic [TEMP_W:0] r;
    if ((&v[TW_W-1:TEMP_W-1]) || !(|v[TW_W-1:TEMP_W-1]))
      r = {1'b0, v[TEMP_W-1:0]};
    else
      r = v[TW_W-1] ? {1'b1, 1'b1, {(TEMP_W-1){1'b0}}} : {1'b1, 1'b0, {(TEMP_W-1){1'b1}}};
    return r;
  endfunction

  state_t                     state_q;
  logic [1:0]                 step_q;
  logic [CNT_W-1:0]           bit_cnt_q;
  logic                       sat_q;
  logic signed [TEMP_W-1:0]   temp_q;
  logic [RAW_W-1:0]           raw_out_q;
  logic                       sat_flag_q;
  logic                       temp_valid_q;

  logic [RAW_W-1:0]           raw_q;
  logic signed [COEF_W-1:0]   ofs_q, g1_q, g2_q, g3_q;
  logic signed [PROD_W-1:0]   prod_q;
  logic signed [PROD_W-1:0]   mcand_q;
  logic [RAW_W-1:0]           mplier_q;

  logic signed [COEF_W-1:0]   mul_res_d;
  logic signed [COEF_W-1:0]   coef_d;
  logic signed [COEF_W:0]     sum_d;
  logic [COEF_W:0]            add_sat_d;
  logic signed [COEF_W-1:0]   acc_d;
  logic                       add_ovf_d;
  logic [TEMP_W:0]            tmp_sat_d;

  // Taking the upper COEF_W bits is the arithmetic shift by RAW_W (floor toward -inf)
  assign mul_res_d = prod_q[PROD_W-1:RAW_W];

  always_comb begin
    coef_d = ofs_q;
    case (step_q)
      2'd0:    coef_d = g2_q;
      2'd1:    coef_d = g1_q;
      default: coef_d = ofs_q;
    endcase
  end

  assign sum_d     = {mul_res_d[COEF_W-1], mul_res_d} + {coef_d[COEF_W-1], coef_d};
  assign add_sat_d = sat_coef(sum_d);
  assign acc_d     = add_sat_d[COEF_W-1:0];
  assign add_ovf_d = add_sat_d[COEF_W];
  assign tmp_sat_d = sat_temp(acc_d[COEF_W-1:T_SHIFT]);

  // Control: sequencing, saturation latch and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      step_q       <= '0;
      bit_cnt_q    <= '0;
      sat_q        <= 1'b0;
      temp_q       <= '0;
      raw_out_q    <= '0;
      sat_flag_q   <= 1'b0;
      temp_valid_q <= 1'b0;
    end else begin
      temp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: if (raw_valid) state_q <= S_LOAD;
        S_LOAD: begin
          step_q    <= '0;
          bit_cnt_q <= '0;
          sat_q     <= 1'b0;
          state_q   <= S_MUL;
        end
        S_MUL: begin
          bit_cnt_q <= bit_cnt_q + 1'b1;
          if (bit_cnt_q == CNT_W'(RAW_W - 1)) state_q <= S_ADD;
        end
        S_ADD: begin
          bit_cnt_q <= '0;
          step_q    <= step_q + 1'b1;
          sat_q     <= sat_q | add_ovf_d;
          if (step_q == 2'd2) begin
            // Final Horner step: publish so the outputs are live during DONE
            temp_q       <= tmp_sat_d[TEMP_W-1:0];
            sat_flag_q   <= sat_q | add_ovf_d | tmp_sat_d[TEMP_W];
            raw_out_q    <= raw_q;
            temp_valid_q <= 1'b1;
            state_q      <= S_DONE;
          end else begin
            state_q <= S_MUL;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Datapath: snapshots and shift-add multiplier, no reset needed
  always_ff @(posedge clk) begin
    case (state_q)
      S_IDLE: if (raw_valid) begin
        raw_q <= raw_data;
        ofs_q <= ofs;
        g1_q  <= gain1;
        g2_q  <= gain2;
        g3_q  <= gain3;
      end
      S_LOAD: begin
        mcand_q  <= {{RAW_W{g3_q[COEF_W-1]}}, g3_q};
        mplier_q <= raw_q;
        prod_q   <= '0;
      end
      S_MUL: begin
        prod_q   <= prod_q + (mplier_q[0] ? mcand_q : '0);
        mcand_q  <= mcand_q <<< 1;
        mplier_q <= mplier_q >> 1;
      end
      S_ADD: begin
        mcand_q  <= {{RAW_W{acc_d[COEF_W-1]}}, acc_d};
        mplier_q <= raw_q;
        prod_q   <= '0;
      end
      default: ;
    endcase
  end

  assign raw_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign temp_out   = temp_q;
  assign raw_out    = raw_out_q;
  assign sat_flag   = sat_flag_q;
  assign temp_valid = temp_valid_q;

endmodule

// File: tb/tb_temp_poly_converter.sv
// Bench for temp_poly_converter: arithmetic model + per-cycle output compare + directed vectors.
module tb_temp_poly_converter;

  logic        clk = 1'b0;
  logic        rst;
  logic        raw_valid;
  logic [15:0] raw_data;
  logic        raw_ready;
  logic [31:0] ofs, gain1, gain2, gain3;
  logic [15:0] temp_out;
  logic [15:0] raw_out;
  logic        temp_valid;
  logic        busy;
  logic        sat_flag;

  always #5 clk = ~clk;

  temp_poly_converter dut (
    .clk        (clk),
    .rst        (rst),
    .raw_valid  (raw_valid),
    .raw_data   (raw_data),
    .raw_ready  (raw_ready),
    .ofs        (ofs),
    .gain1      (gain1),
    .gain2      (gain2),
    .gain3      (gain3),
    .temp_out   (temp_out),
    .raw_out    (raw_out),
    .temp_valid (temp_valid),
    .busy       (busy),
    .sat_flag   (sat_flag)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit check_en = 1'b0;

  // Calibration polynomial in plain integer arithmetic
  function automatic void model_conv(input logic [15:0] r, input logic [31:0] o, g1, g2, g3,
                                     output logic [15:0] t, output logic s);
    longint acc, c;
    s   = 1'b0;
    acc = longint'($signed(g3));
    for (int k = 0; k < 3; k++) begin
      c   = (k == 0) ? longint'($signed(g2)) : (k == 1) ? longint'($signed(g1)) : longint'($signed(o));
      acc = ((acc * longint'(r)) >>> 16) + c;
      if (acc > 64'sd2147483647)       begin acc = 64'sd2147483647;  s = 1'b1; end
      else if (acc < -64'sd2147483648) begin acc = -64'sd2147483648; s = 1'b1; end
    end
    acc = acc >>> 12;
    if (acc > 64'sd32767)       begin acc = 64'sd32767;  s = 1'b1; end
    else if (acc < -64'sd32768) begin acc = -64'sd32768; s = 1'b1; end
    t = acc[15:0];
  endfunction

  // Transaction-level expectation: cycles remaining in the current conversion
  int          cnt = 0;
  logic [15:0] exp_temp = '0, exp_raw = '0, pend_temp, pend_raw;
  logic        exp_sat = 1'b0, pend_sat;

  always @(posedge clk) begin
    if (rst) begin
      cnt = 0; exp_temp = '0; exp_raw = '0; exp_sat = 1'b0;
    end else if (cnt == 0) begin
      if (raw_valid) begin
        cnt = 53;
        model_conv(raw_data, ofs, gain1, gain2, gain3, pend_temp, pend_sat);
        pend_raw = raw_data;
      end
    end else begin
      cnt = cnt - 1;
      if (cnt == 1) begin
        exp_temp = pend_temp; exp_raw = pend_raw; exp_sat = pend_sat;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      n_tests++;
      if (temp_valid !== (cnt == 1) || raw_ready !== (cnt == 0) || busy !== (cnt != 0) ||
          temp_out !== exp_temp || raw_out !== exp_raw || sat_flag !== exp_sat) begin
        n_fail++;
        $display("FAIL cycle_check t=%0t: got tv=%b rdy=%b busy=%b temp=%h raw=%h sat=%b, expected tv=%b rdy=%b busy=%b temp=%h raw=%h sat=%b",
                 $time, temp_valid, raw_ready, busy, temp_out, raw_out, sat_flag,
                 (cnt == 1), (cnt == 0), (cnt != 0), exp_temp, exp_raw, exp_sat);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic wait_valid(input string name, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (temp_valid === 1'b1) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: got no temp_valid within 70 cycles, expected one", name);
    end
  endtask

  task automatic run_conv(input string name, input logic [15:0] r, input logic [31:0] o, g1, g2, g3,
                          input logic [15:0] et, input logic es);
    logic [15:0] mt;
    logic        ms;
    bit          seen;
    model_conv(r, o, g1, g2, g3, mt, ms);
    check({name, "_model_temp"}, 32'(mt), 32'(et));
    check({name, "_model_sat"}, 32'(ms), 32'(es));
    @(posedge clk); #1;
    raw_data = r; ofs = o; gain1 = g1; gain2 = g2; gain3 = g3; raw_valid = 1'b1;
    @(posedge clk); #1;
    raw_valid = 1'b0;
    wait_valid(name, seen);
    if (seen) begin
      check({name, "_temp"}, 32'(temp_out), 32'(et));
      check({name, "_sat"}, 32'(sat_flag), 32'(es));
      check({name, "_raw"}, 32'(raw_out), 32'(r));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int stray;
    rst = 1'b1; raw_valid = 1'b0; raw_data = '0;
    ofs = '0; gain1 = '0; gain2 = '0; gain3 = '0;
    @(posedge clk); #1;
    check_en = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(raw_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(temp_valid), 32'd0);
    check("rst_temp", 32'(temp_out), 32'd0);
    check("rst_raw", 32'(raw_out), 32'd0);
    check("rst_sat", 32'(sat_flag), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_conv("ofs25",       16'h1234, 32'h01900000, 32'h0, 32'h0, 32'h0, 16'h1900, 1'b0);
    run_conv("gain1_half",  16'h8000, 32'h0, 32'h00100000, 32'h0, 32'h0, 16'h0080, 1'b0);
    run_conv("gain2_qtr",   16'h8000, 32'h0, 32'h0, 32'h00100000, 32'h0, 16'h0040, 1'b0);
    run_conv("ofs_neg10",   16'h5555, 32'hFF600000, 32'h0, 32'h0, 32'h0, 16'hF600, 1'b0);
    run_conv("pos_sat",     16'hFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0, 32'h0, 16'h7FFF, 1'b1);
    run_conv("neg_sat",     16'hFFFF, 32'h80000000, 32'h80000000, 32'h0, 32'h0, 16'h8000, 1'b1);
    run_conv("temp_clamp",  16'h0000, 32'h08000000, 32'h0, 32'h0, 32'h0, 16'h7FFF, 1'b1);
    run_conv("raw0_ofs",    16'h0000, 32'h01900000, 32'h00100000, 32'h00100000, 32'h00100000, 16'h1900, 1'b0);
    run_conv("gain3_neg",   16'h8000, 32'h0, 32'h0, 32'h0, 32'hFFF00000, 16'hFFE0, 1'b0);
    run_conv("raw_max",     16'hFFFF, 32'h0, 32'h00100000, 32'h0, 32'h0, 16'h00FF, 1'b0);
    run_conv("ofs_plus_g1", 16'h8000, 32'h01900000, 32'h00100000, 32'h0, 32'h0, 16'h1980, 1'b0);

    // Coefficient change and stray raw_valid during a conversion
    @(posedge clk); #1;
    raw_data = 16'h0100; ofs = 32'h01900000; gain1 = '0; gain2 = '0; gain3 = '0; raw_valid = 1'b1;
    @(posedge clk); #1;
    raw_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 ofs = 32'h00A00000;
    repeat (10) @(posedge clk);
    #1 raw_data = 16'h7777; raw_valid = 1'b1;
    @(posedge clk); #1;
    raw_valid = 1'b0;
    wait_valid("hs", seen);
    if (seen) begin
      check("hs_temp", 32'(temp_out), 32'h1900);
      check("hs_raw", 32'(raw_out), 32'h0100);
    end

    // Reset at cycle 30 of a conversion, with raw_valid high alongside rst
    @(posedge clk); #1;
    raw_data = 16'h4000; raw_valid = 1'b1;
    @(posedge clk); #1;
    raw_valid = 1'b0;
    repeat (29) @(posedge clk);
    #1 rst = 1'b1; raw_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; raw_valid = 1'b0;
    @(negedge clk);
    check("after_rst_ready", 32'(raw_ready), 32'd1);
    check("after_rst_temp", 32'(temp_out), 32'd0);
    stray = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (temp_valid === 1'b1) stray++;
    end
    check("no_valid_after_rst", 32'(stray), 32'd0);
    run_conv("after_rst", 16'h4000, 32'h00A00000, 32'h0, 32'h0, 32'h0, 16'h0A00, 1'b0);

    repeat (3) @(posedge clk);
    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
